// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register bank write port.
// The slave modport is the arbiter's view; the master modport is the requester/bank side.
interface regfile_write_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            we;
  logic [AW-1:0]   ain;
  logic [XLEN-1:0] din;
  logic            busy;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output we, ain, din, busy
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  we, ain, din, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank write port between requesters A and B (round-robin on ties),
// zeroes the bank after reset and silently drops writes to r0 in normal operation.
module regfile_write_arbiter #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW            = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  state_e          state_q, state_d;
  last_e           last_q, last_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [AW-1:0]   ain_q, ain_d;
  logic [XLEN-1:0] din_q, din_d;
  logic            busy_q, busy_d;
  logic            grant_a, grant_b;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    ain_d   = ain_q;
    din_d   = din_q;
    // busy lags the state by one cycle so it covers the cycle presenting the last clear write
    busy_d  = (state_q != ST_RUN);
    grant_a = 1'b0;
    grant_b = 1'b0;

    case (state_q)
      ST_INIT: begin
        we_d  = 1'b1;
        ain_d = idx_q;
        din_d = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.a_valid && (!bus.b_valid || last_q == LAST_B)) begin
          grant_a = 1'b1;
        end else if (bus.b_valid) begin
          grant_b = 1'b1;
        end

        if (grant_a) begin
          we_d   = (bus.a_addr != '0);
          ain_d  = bus.a_addr;
          din_d  = bus.a_data;
          last_d = LAST_A;
        end else if (grant_b) begin
          we_d   = (bus.b_addr != '0);
          ain_d  = bus.b_addr;
          din_d  = bus.b_data;
          last_d = LAST_B;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      last_q  <= LAST_B;
      idx_q   <= '0;
      we_q    <= 1'b0;
      ain_q   <= '0;
      din_q   <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      ain_q   <= ain_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign bus.we      = we_q;
  assign bus.ain     = ain_q;
  assign bus.din     = din_q;
  assign bus.busy    = busy_q;

endmodule
